// File: rtl/spi_sd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_sd_pkg
// Purpose  : Encodings and constants shared by the SD SPI-mode command
//            receiver and response transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package spi_sd_pkg;

    typedef enum logic [1:0] {
        RESP_R1   = 2'd0,
        RESP_R3   = 2'd1,
        RESP_R7   = 2'd2,
        RESP_RSVD = 2'd3
    } resp_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NCR   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } tx_state_t;

    localparam int unsigned C_R1_IDLE_BIT        = 0;
    localparam int unsigned C_R1_ILLEGAL_CMD_BIT = 2;
    localparam logic [7:0]  C_FILL_BYTE          = 8'hFF;
    localparam int unsigned C_SHIFT_W            = 40;
    localparam int unsigned C_CNT_W              = 9;

    // The reserved encoding is answered as a plain R1.
    function automatic resp_kind_t norm_kind(input logic [1:0] kind);
        return (kind == RESP_RSVD) ? RESP_R1 : resp_kind_t'(kind);
    endfunction

    // Index of the last response bit, counted down to zero while shifting.
    function automatic logic [C_CNT_W-1:0] resp_last_bit(input resp_kind_t kind);
        return (kind == RESP_R1) ? C_CNT_W'(7) : C_CNT_W'(39);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_clk_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : spi_clk_edge_detect
// Purpose  : Synchronises the host SPI clock and chip select, and produces
//            single-cycle fall/rise pulses of the SPI clock.
// Revision : 1.0 - initial release
// ============================================================================
module spi_clk_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_spi_clk,
    input  logic i_cs,
    output logic o_cs,
    output logic o_fall,
    output logic o_rise
);

    logic w_spi_cur;
    logic r_spi_prev;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [SYNC_STAGES-1:0] r_clk_sync;
            logic [SYNC_STAGES-1:0] r_cs_sync;

            // Chip select resets to deselected so nothing aborts or counts early.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_clk_sync <= '0;
                    r_cs_sync  <= '1;
                end else begin
                    r_clk_sync[0] <= i_spi_clk;
                    r_cs_sync[0]  <= i_cs;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_clk_sync[i] <= r_clk_sync[i-1];
                        r_cs_sync[i]  <= r_cs_sync[i-1];
                    end
                end
            end

            assign w_spi_cur = r_clk_sync[SYNC_STAGES-1];
            assign o_cs      = r_cs_sync[SYNC_STAGES-1];
        end else begin : g_bypass
            assign w_spi_cur = i_spi_clk;
            assign o_cs      = i_cs;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_spi_prev <= 1'b0;
        end else begin
            r_spi_prev <= w_spi_cur;
        end
    end

    assign o_fall = r_spi_prev & ~w_spi_cur;
    assign o_rise = ~r_spi_prev & w_spi_cur;

endmodule
`default_nettype wire

// File: rtl/spi_response_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : spi_response_transmitter
// Purpose  : Sends SD SPI-mode R1/R3/R7 responses MSB-first on DO, preceded
//            by NCR_BYTES fill bytes, changing DO after host SPI clock falls.
// Revision : 1.0 - initial release
// ============================================================================
module spi_response_transmitter
    import spi_sd_pkg::*;
#(
    parameter int NCR_BYTES   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_SpiClk,
    input  logic        io_CS,
    input  logic        io_RespValid,
    input  logic [1:0]  io_RespKind,
    input  logic [7:0]  io_R1,
    input  logic [31:0] io_Payload,
    output logic        io_RespReady,
    output logic        io_DO,
    output logic        io_Busy,
    output logic        io_Done
);

    localparam logic [C_CNT_W-1:0] C_NCR_LAST = C_CNT_W'(8 * NCR_BYTES - 1);
    localparam logic               C_DO_IDLE  = C_FILL_BYTE[7];

    tx_state_t              r_state,   w_state_nxt;
    resp_kind_t             r_kind,    w_kind_nxt;
    logic [C_SHIFT_W-1:0]   r_shift,   w_shift_nxt;
    logic [C_CNT_W-1:0]     r_bit_cnt, w_bit_cnt_nxt;
    logic                   r_do,      w_do_nxt;

    logic w_cs_high;
    logic w_spi_fall;
    logic w_spi_rise_unused;
    logic w_fall_en;

    spi_clk_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge (
        .clk       (clock),
        .rst       (reset),
        .i_spi_clk (io_SpiClk),
        .i_cs      (io_CS),
        .o_cs      (w_cs_high),
        .o_fall    (w_spi_fall),
        .o_rise    (w_spi_rise_unused)
    );

    // Falls seen while deselected never advance the transfer.
    assign w_fall_en = w_spi_fall & ~w_cs_high;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_kind    <= RESP_R1;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_do      <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_kind    <= w_kind_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_do      <= w_do_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_kind_nxt    = r_kind;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_do_nxt      = r_do;

        unique case (r_state)
            ST_IDLE: begin
                w_do_nxt = C_DO_IDLE;
                if (io_RespValid) begin
                    w_kind_nxt    = norm_kind(io_RespKind);
                    w_shift_nxt   = {io_R1, io_Payload};
                    w_bit_cnt_nxt = C_NCR_LAST;
                    w_state_nxt   = ST_NCR;
                end
            end
            ST_NCR: begin
                w_do_nxt = C_DO_IDLE;
                if (w_cs_high) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_fall_en) begin
                    if (r_bit_cnt == '0) begin
                        // The fall that ends the gap already carries the first bit.
                        w_state_nxt   = ST_SHIFT;
                        w_bit_cnt_nxt = resp_last_bit(r_kind);
                        w_do_nxt      = r_shift[C_SHIFT_W-1];
                        w_shift_nxt   = r_shift << 1;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt - 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (w_cs_high) begin
                    w_do_nxt    = C_DO_IDLE;
                    w_state_nxt = ST_IDLE;
                end else if (w_fall_en) begin
                    if (r_bit_cnt == '0) begin
                        w_do_nxt    = C_DO_IDLE;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_do_nxt      = r_shift[C_SHIFT_W-1];
                        w_shift_nxt   = r_shift << 1;
                        w_bit_cnt_nxt = r_bit_cnt - 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_do_nxt    = C_DO_IDLE;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_do_nxt    = C_DO_IDLE;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign io_DO        = r_do;
    assign io_RespReady = (r_state == ST_IDLE);
    assign io_Busy      = (r_state != ST_IDLE);
    assign io_Done      = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_spi_response_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_response_transmitter
// Purpose  : Self-checking bench acting as SPI host for two transmitters
//            (NCR_BYTES=1 with synchroniser, NCR_BYTES=3 without).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_response_transmitter;

    typedef struct {
        logic [1:0]  kind;
        logic [7:0]  r1;
        logic [31:0] payload;
        int          resp_bytes;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_clk = 1'b0;
    logic        cs_n = 1'b0;
    logic        valid = 1'b0;
    logic [1:0]  kind = 2'd0;
    logic [7:0]  r1 = 8'd0;
    logic [31:0] payload = 32'd0;

    logic ready_a, do_a, busy_a, done_a;
    logic ready_b, do_b, busy_b, done_b;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;
    int base_a, base_b;
    int unstable_a, unstable_b;

    logic bits_a [128];
    logic bits_b [128];
    logic bsy_a  [128];
    logic bsy_b  [128];

    always #5 clk = ~clk;

    spi_response_transmitter #(.NCR_BYTES(1), .SYNC_STAGES(2)) u_dut_a (
        .clock(clk), .reset(rst), .io_SpiClk(spi_clk), .io_CS(cs_n),
        .io_RespValid(valid), .io_RespKind(kind), .io_R1(r1), .io_Payload(payload),
        .io_RespReady(ready_a), .io_DO(do_a), .io_Busy(busy_a), .io_Done(done_a)
    );

    spi_response_transmitter #(.NCR_BYTES(3), .SYNC_STAGES(0)) u_dut_b (
        .clock(clk), .reset(rst), .io_SpiClk(spi_clk), .io_CS(cs_n),
        .io_RespValid(valid), .io_RespKind(kind), .io_R1(r1), .io_Payload(payload),
        .io_RespReady(ready_b), .io_DO(do_b), .io_Busy(busy_b), .io_Done(done_b)
    );

    always @(posedge clk) begin
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Byte the host should read at position idx: fill, R1, then payload MSB first, then idle.
    function automatic logic [7:0] exp_byte(input int idx, input logic [7:0] r1v,
                                            input logic [31:0] pl, input int nbytes, input int ncr);
        int b;
        b = idx - ncr;
        if (idx < ncr) return 8'hFF;
        if (b == 0) return r1v;
        if (b < nbytes) return pl[8*(4-b) +: 8];
        return 8'hFF;
    endfunction

    task automatic send_req(input string tag, input logic [1:0] k, input logic [7:0] r,
                            input logic [31:0] p);
        @(negedge clk);
        valid = 1'b1; kind = k; r1 = r; payload = p;
        @(negedge clk);
        valid = 1'b0;
        chk({tag, " A ready drop"}, ready_a, 1'b0);
        chk({tag, " B busy"}, busy_b, 1'b1);
    endtask

    // Host clocks n bits: sample on rise, hold high, fall; optional busy-time request pulse.
    task automatic spi_bits(input int n, input int pulse_at);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bits_a[i] = do_a; bits_b[i] = do_b;
            bsy_a[i]  = busy_a; bsy_b[i] = busy_b;
            spi_clk = 1'b1;
            if (i == pulse_at) begin
                valid = 1'b1; kind = 2'd0; r1 = 8'h7F;
            end
            repeat (8) begin
                @(negedge clk);
                valid = 1'b0;
                if (do_a !== bits_a[i]) unstable_a++;
                if (do_b !== bits_b[i]) unstable_b++;
            end
            spi_clk = 1'b0;
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic check_stream(input string tag, input logic [7:0] r, input logic [31:0] p,
                                input int nbytes, input int nbits);
        for (int inst = 0; inst < 2; inst++) begin
            int ncr, lows;
            logic [7:0] act;
            ncr = (inst == 0) ? 1 : 3;
            for (int j = 0; j < nbits / 8; j++) begin
                for (int k = 0; k < 8; k++)
                    act[7-k] = (inst == 0) ? bits_a[8*j+k] : bits_b[8*j+k];
                chk($sformatf("%s %s byte%0d", tag, inst == 0 ? "A" : "B", j),
                    act, exp_byte(j, r, p, nbytes, ncr));
            end
            lows = 0;
            for (int i = 0; i < 8 * (ncr + nbytes); i++)
                if (((inst == 0) ? bsy_a[i] : bsy_b[i]) !== 1'b1) lows++;
            chk($sformatf("%s %s busy lows", tag, inst == 0 ? "A" : "B"), lows, 0);
        end
        chk({tag, " A unstable"}, unstable_a, 0);
        chk({tag, " B unstable"}, unstable_b, 0);
        chk({tag, " A done count"}, done_cnt_a - base_a, 1);
        chk({tag, " B done count"}, done_cnt_b - base_b, 1);
        chk({tag, " idle flags"}, {ready_a, busy_a, do_a, ready_b, busy_b, do_b}, 6'b101_101);
    endtask

    task automatic run_resp(input string tag, input logic [1:0] k, input logic [7:0] r,
                            input logic [31:0] p, input int nbytes, input int pulse_at);
        int nbits;
        nbits = 8 * (3 + nbytes + 1);
        base_a = done_cnt_a; base_b = done_cnt_b;
        unstable_a = 0; unstable_b = 0;
        send_req(tag, k, r, p);
        spi_bits(nbits, pulse_at);
        repeat (4) @(negedge clk);
        check_stream(tag, r, p, nbytes, nbits);
    endtask

    initial begin
        vec_t tbl [5];
        tbl[0] = '{kind: 2'd0, r1: 8'h01, payload: 32'h0000_0000, resp_bytes: 1};  // CMD0
        tbl[1] = '{kind: 2'd2, r1: 8'h01, payload: 32'h0000_01AA, resp_bytes: 5};  // CMD8
        tbl[2] = '{kind: 2'd0, r1: 8'h05, payload: 32'h1234_5678, resp_bytes: 1};  // illegal cmd
        tbl[3] = '{kind: 2'd1, r1: 8'h00, payload: 32'hC0FF_8000, resp_bytes: 5};  // R3
        tbl[4] = '{kind: 2'd3, r1: 8'h3C, payload: 32'hDEAD_BEEF, resp_bytes: 1};  // reserved

        repeat (3) @(negedge clk);
        chk("reset flags", {ready_a, busy_a, do_a, done_a, ready_b, busy_b, do_b, done_b},
            8'b1010_1010);
        rst = 1'b0;
        @(negedge clk);
        chk("post reset flags", {ready_a, busy_a, do_a, ready_b, busy_b, do_b}, 6'b101_101);

        for (int t = 0; t < 5; t++)
            run_resp($sformatf("tbl%0d", t), tbl[t].kind, tbl[t].r1, tbl[t].payload,
                     tbl[t].resp_bytes, -1);

        for (int t = 0; t < 6; t++) begin
            logic [1:0]  rk;
            logic [7:0]  rr;
            logic [31:0] rp;
            rk = 2'($urandom_range(0, 3));
            rr = {1'b0, 7'($urandom)};
            rp = $urandom;
            run_resp($sformatf("rnd%0d", t), rk, rr, rp, (rk == 2'd1 || rk == 2'd2) ? 5 : 1, -1);
        end

        // Chip-select abort part-way through an R7.
        base_a = done_cnt_a; base_b = done_cnt_b;
        send_req("abort", 2'd2, 8'h01, 32'h0000_01AA);
        spi_bits(12, -1);
        cs_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort flags", {ready_a, busy_a, do_a, ready_b, busy_b, do_b}, 6'b101_101);
        chk("abort A no done", done_cnt_a - base_a, 0);
        chk("abort B no done", done_cnt_b - base_b, 0);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        run_resp("after abort", 2'd0, 8'h00, 32'h0, 1, -1);

        // Request strobed while both transmitters are busy must be dropped.
        run_resp("busy req", 2'd0, 8'h01, 32'h0, 1, 10);

        // Synchronous reset in the middle of shifting.
        base_a = done_cnt_a; base_b = done_cnt_b;
        send_req("midreset", 2'd2, 8'h01, 32'h1234_5678);
        spi_bits(30, -1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset flags", {ready_a, busy_a, do_a, done_a, ready_b, busy_b, do_b, done_b},
            8'b1010_1010);
        chk("midreset no done", (done_cnt_a - base_a) + (done_cnt_b - base_b), 0);
        repeat (4) @(negedge clk);
        run_resp("after reset R3", 2'd1, 8'h00, 32'hC0FF_8000, 5, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
